cam_cfg_sequencer: RTL
======================

Name: cam_cfg_sequencer

Overview:
- Consumes the OV7670 configuration ROM: steps its address, decodes each 16-bit {register, value} word and issues one SCCB 3-phase write per entry.
- Implements the two ROM markers: 16'hFFF0 inserts a wait; 16'hFFFF ends the sequence.
- Sits between the config ROM and the camera SIOC/SIOD pins; the top level builds the open-drain SIOD pad from siod_o/siod_oe.

Parameters:
- CLK_FREQ_HZ, 25_000_000, system clock frequency.
- SCCB_FREQ_HZ, 100_000, SIOC bit rate; QUARTER = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) cycles, integer division.
- DELAY_MS, 10, wait for the FFF0 marker; DELAY_CYCLES = (CLK_FREQ_HZ/1000)*DELAY_MS.
- DEV_ADDR, 8'h42, SCCB write address of the camera.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sequence from address 0
- rom_addr  out  8  address to the config ROM
- rom_data  in  16  ROM word; registered ROM, valid 1 cycle after rom_addr changes
- sioc  out  1  SCCB clock, push-pull
- siod_o  out  1  SCCB data value
- siod_oe  out  1  1 = drive siod_o; 0 = release (pulled high)
- busy  out  1  high from accepted start until done
- done  out  1  level; high after FFFF is reached, cleared by the next start

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rom_addr=0, sioc=1, siod_o=1, siod_oe=1, busy=0, done=0; FSM in IDLE.
- rst mid-transaction forces the bus to idle (both lines high) on the next edge. No stop condition is generated.
- Sequencer FSM:
  - IDLE: on start, set rom_addr=0 and busy=1, clear done, go to FETCH.
  - FETCH: wait 1 cycle for ROM latency, then go to DECODE.
  - DECODE, selected on rom_data:
    - FFFF: go to FINISH.
    - FFF0: load the delay counter, go to DELAY.
    - Any other word: pulse the write request with reg=rom_data[15:8] and val=rom_data[7:0], go to WRITE.
  - WRITE: wait for the sub-module's wr_done, then go to GAP.
  - GAP: bus idle for 4*QUARTER cycles, then go to NEXT.
  - DELAY: count DELAY_CYCLES with no bus activity, then go to NEXT.
  - NEXT:
    - If rom_addr==255, go to FINISH (no wrap).
    - Otherwise rom_addr++ and go to FETCH.
  - FINISH: busy=0, done=1, go to IDLE.
- start is ignored while busy=1.
- start in the same cycle as rst is ignored.
- SCCB write, each bit = 4 quarter-periods q0..q3:
  - START: q0 SIOD=1/SIOC=1; q1 SIOD=0/SIOC=1; q2–q3 SIOD=0/SIOC=0.
  - 27 data bits: DEV_ADDR, X, reg, X, val, X. Each group is MSB first.
    - Per bit: SIOD changes in q0 with SIOC=0; SIOC=1 in q1–q2; SIOC=0 in q3.
    - The X (don't-care) bits have siod_oe=0 for all four quarters; the ack is not checked.
  - STOP: q0 SIOD=0/SIOC=0; q1 SIOD=0/SIOC=1; q2–q3 SIOD=1/SIOC=1.
  - Total 29 bit periods = 116*QUARTER cycles, then wr_done pulses 1 cycle.
- Outside transactions: sioc=1, siod_o=1, siod_oe=1.

Optional Feature:
- Macro CFG_AUTOSTART_EN.
- Defined: one cycle after rst deasserts, the FSM behaves as if start were pulsed; start still works afterwards.
- Undefined: the sequence runs only on an explicit start pulse.

Decomposition:
- Package cam_cfg_pkg holds:
  - sequencer state encoding;
  - marker constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0;
  - SCCB phase encoding (START, BIT, STOP);
  - the bit count 27.
- Sub-module sccb_write3 holds the quarter-tick divider, the bit/quarter counters and the shift register.
  - Inputs: wr_req, dev, reg, val.
  - Outputs: sioc, siod_o, siod_oe, wr_done.

Test Plan (CLK_FREQ_HZ=4_000_000, SCCB_FREQ_HZ=100_000 → QUARTER=10; DELAY_MS=1 → 4000 cycles):
- ROM model {0:1280, 1:FFFF}, start → one write decoded as bytes 42/12/80.
  - X bits have siod_oe=0.
  - Transaction lasts 1160 cycles.
  - done=1 after the GAP, rom_addr ends at 1.
- ROM {0:1280, 1:FFF0, 2:1204, 3:FFFF} → writes 12/80 and 12/04, with ≥4000 idle cycles between them; done=1.
- rst asserted 300 cycles into a write → next edge: sioc=1, siod_o=1, siod_oe=1, busy=0.
  - A later start re-sends from address 0.
- start pulsed while busy → ignored; the write count and rom_addr sequence are unchanged.
- ROM returning 0x1100 at every address (no FFFF) → 256 writes, stops at rom_addr=255 with done=1, no wrap to 0.
- With CFG_AUTOSTART_EN: release rst, no start → busy=1 one cycle later and the first write begins.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer and its SCCB writer.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WRITE,
        ST_GAP,
        ST_DELAY,
        ST_NEXT,
        ST_FINISH
    } seq_state_t;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_START,
        PH_BIT,
        PH_STOP
    } sccb_phase_t;

    localparam int SCCB_BITS = 27;

    // The ninth bit of every byte group is the camera's don't-care/ack slot.
    function automatic logic is_ack_bit(input logic [4:0] idx);
        return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
    endfunction

endpackage

// File: rtl/sccb_write3.sv
// SCCB 3-phase write engine: START, 27 data bits (dev/X/reg/X/val/X), STOP.
module sccb_write3
    import cam_cfg_pkg::*;
#(
    parameter int QUARTER = 62
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [7:0] dev,
    input  logic [7:0] reg_addr,
    input  logic [7:0] val,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe,
    output logic       wr_done
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    sccb_phase_t phase, nxt_phase;
    logic [1:0]    qtr, nxt_qtr;
    logic [QW-1:0] cnt, nxt_cnt;
    logic [4:0]    bidx, nxt_bidx;
    logic [26:0]   shift, nxt_shift;
    logic          nxt_done;
    logic          line_c, line_d, line_oe;

    always_comb begin
        nxt_phase = phase;
        nxt_qtr   = qtr;
        nxt_cnt   = cnt;
        nxt_bidx  = bidx;
        nxt_shift = shift;
        nxt_done  = 1'b0;
        if (phase == PH_IDLE) begin
            if (wr_req) begin
                nxt_phase = PH_START;
                nxt_qtr   = 2'd0;
                nxt_cnt   = '0;
                nxt_bidx  = 5'd0;
                nxt_shift = {dev, 1'b1, reg_addr, 1'b1, val, 1'b1};
            end
        end else if (cnt == QW'(QUARTER - 1)) begin
            nxt_cnt = '0;
            if (qtr == 2'd3) begin
                nxt_qtr = 2'd0;
                case (phase)
                    PH_START: begin
                        nxt_phase = PH_BIT;
                        nxt_bidx  = 5'd0;
                    end
                    PH_BIT: begin
                        if (bidx == 5'(SCCB_BITS - 1)) begin
                            nxt_phase = PH_STOP;
                        end else begin
                            nxt_bidx  = bidx + 5'd1;
                            nxt_shift = {shift[25:0], 1'b1};
                        end
                    end
                    default: begin
                        nxt_phase = PH_IDLE;
                        nxt_done  = 1'b1;
                    end
                endcase
            end else begin
                nxt_qtr = qtr + 2'd1;
            end
        end else begin
            nxt_cnt = cnt + QW'(1);
        end
    end

    // Line levels are derived from the upcoming state so the pins change on the same edge as the phase.
    always_comb begin
        line_c  = 1'b1;
        line_d  = 1'b1;
        line_oe = 1'b1;
        case (nxt_phase)
            PH_START: begin
                line_c = (nxt_qtr < 2'd2);
                line_d = (nxt_qtr == 2'd0);
            end
            PH_BIT: begin
                line_c  = (nxt_qtr == 2'd1) || (nxt_qtr == 2'd2);
                line_oe = !is_ack_bit(nxt_bidx);
                line_d  = line_oe ? nxt_shift[26] : 1'b1;
            end
            PH_STOP: begin
                line_c = (nxt_qtr != 2'd0);
                line_d = (nxt_qtr >= 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_IDLE;
            qtr     <= 2'd0;
            cnt     <= '0;
            bidx    <= 5'd0;
            shift   <= '1;
            sioc    <= 1'b1;
            siod_o  <= 1'b1;
            siod_oe <= 1'b1;
            wr_done <= 1'b0;
        end else begin
            phase   <= nxt_phase;
            qtr     <= nxt_qtr;
            cnt     <= nxt_cnt;
            bidx    <= nxt_bidx;
            shift   <= nxt_shift;
            sioc    <= line_c;
            siod_o  <= line_d;
            siod_oe <= line_oe;
            wr_done <= nxt_done;
        end
    end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the OV7670 config ROM and issues one SCCB write per entry (FFF0 = wait, FFFF = end).
// Optional macro CFG_AUTOSTART_EN: launch the sequence automatically right after reset.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int          CLK_FREQ_HZ  = 25_000_000,
    parameter int          SCCB_FREQ_HZ = 100_000,
    parameter int          DELAY_MS     = 10,
    parameter logic [7:0]  DEV_ADDR     = 8'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);

    localparam int QUARTER      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int DELAY_CYCLES = (CLK_FREQ_HZ / 1000) * DELAY_MS;
    localparam int GAP_CYCLES   = 4 * QUARTER;

    seq_state_t  state;
    logic [31:0] wait_cnt;
    logic        wr_req;
    logic        wr_done;
    logic [7:0]  wr_reg;
    logic [7:0]  wr_val;
    logic        start_eff;

`ifdef CFG_AUTOSTART_EN
    logic auto_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_pend <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    assign start_eff = start | auto_pend;
`else
    assign start_eff = start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rom_addr <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_req   <= 1'b0;
            wr_reg   <= 8'd0;
            wr_val   <= 8'd0;
            wait_cnt <= 32'd0;
        end else begin
            wr_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_eff) begin
                        rom_addr <= 8'd0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (rom_data == CFG_END) begin
                        state <= ST_FINISH;
                    end else if (rom_data == CFG_DELAY) begin
                        wait_cnt <= 32'(DELAY_CYCLES - 1);
                        state    <= ST_DELAY;
                    end else begin
                        wr_req <= 1'b1;
                        wr_reg <= rom_data[15:8];
                        wr_val <= rom_data[7:0];
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_done) begin
                        wait_cnt <= 32'(GAP_CYCLES - 1);
                        state    <= ST_GAP;
                    end
                end
                ST_GAP, ST_DELAY: begin
                    if (wait_cnt == 32'd0) begin
                        state <= ST_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end
                ST_NEXT: begin
                    // The ROM is 256 deep; running off the end finishes rather than wrapping.
                    if (rom_addr == 8'd255) begin
                        state <= ST_FINISH;
                    end else begin
                        rom_addr <= rom_addr + 8'd1;
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sccb_write3 #(
        .QUARTER(QUARTER)
    ) u_sccb (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .dev     (DEV_ADDR),
        .reg_addr(wr_reg),
        .val     (wr_val),
        .sioc    (sioc),
        .siod_o  (siod_o),
        .siod_oe (siod_oe),
        .wr_done (wr_done)
    );

endmodule
